// File: rtl/uart_baud_pkg.sv
// Shared types and default sizing for the fractional UART baud-rate generator.
// Optional fractional divisor is enabled with the UART_BAUDGEN_FRAC_EN macro.
package uart_baud_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int OSR_DEF    = 16;
  localparam int PH_W_DEF   = $clog2(OSR_DEF);

  typedef logic [DIV_W_DEF-1:0]  div_t;
  typedef logic [FRAC_W_DEF-1:0] frac_t;
  typedef logic [PH_W_DEF-1:0]   phase_t;

  // Phase that precedes the mid-bit sample phase (OSR/2-1).
  function automatic int sample_pre_phase(input int osr);
    return osr / 2 - 2;
  endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional phase accumulator: on every period end adds FRAC and turns the
// carry-out into a one-cycle period extension for the following period.
module uart_baud_frac_acc
  import uart_baud_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              clear,
  input  logic              adv,
  input  logic [FRAC_W-1:0] frac,
  output logic              stretch
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc     <= '0;
      stretch <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      stretch <= 1'b0;
    end else if (adv) begin
      acc     <= sum[FRAC_W-1:0];
      stretch <= sum[FRAC_W];
    end
  end

endmodule

// File: rtl/uart_baudgen_frac.sv
// UART baud-rate generator: oversample, bit-boundary and mid-bit sample ticks.
// Define UART_BAUDGEN_FRAC_EN to enable the fractional divisor extension.
module uart_baudgen_frac
  import uart_baud_pkg::*;
#(
  parameter  int DIV_W  = DIV_W_DEF,
  parameter  int FRAC_W = FRAC_W_DEF,
  parameter  int OSR    = OSR_DEF,
  localparam int PH_W   = $clog2(OSR)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CE,
  input  logic              CLEAR,
  input  logic [DIV_W-1:0]  DIVIDER,
  input  logic [FRAC_W-1:0] FRAC,
  output logic              BAUDTICK,
  output logic              BITTICK,
  output logic              SAMPLETICK,
  output logic [PH_W-1:0]   PHASE,
  output logic              DIV_ZERO
);

  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_SAMPRE = PH_W'(sample_pre_phase(OSR));

  // One extra bit so DIVIDER all-ones plus a stretch cycle cannot wrap.
  logic [DIV_W:0] cnt;
  logic [DIV_W:0] target;
  logic           stretch;
  logic           div_nz;
  logic           period_end;

  assign div_nz     = |DIVIDER;
  assign target     = {1'b0, DIVIDER} + {{DIV_W{1'b0}}, stretch};
  assign period_end = CE && div_nz && (cnt >= target);

`ifdef UART_BAUDGEN_FRAC_EN
  uart_baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .clear   (CLEAR),
    .adv     (period_end && !CLEAR),
    .frac    (FRAC),
    .stretch (stretch)
  );
`else
  logic unused_frac;
  assign unused_frac = ^FRAC;
  assign stretch     = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt        <= '0;
      PHASE      <= '0;
      BAUDTICK   <= 1'b0;
      BITTICK    <= 1'b0;
      SAMPLETICK <= 1'b0;
      DIV_ZERO   <= 1'b0;
    end else begin
      BAUDTICK   <= 1'b0;
      BITTICK    <= 1'b0;
      SAMPLETICK <= 1'b0;
      DIV_ZERO   <= !div_nz;
      if (CLEAR) begin
        cnt   <= '0;
        PHASE <= '0;
      end else if (CE && div_nz) begin
        // >= rather than == so a DIVIDER lowered mid-period ends it at once.
        if (period_end) begin
          cnt        <= '0;
          BAUDTICK   <= 1'b1;
          BITTICK    <= (PHASE == PH_LAST);
          SAMPLETICK <= (PHASE == PH_SAMPRE);
          PHASE      <= PHASE + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Randomised self-checking bench for uart_baudgen_frac against a tick-count model.
module tb_uart_baudgen_frac;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;
  localparam int PH_W   = 4;

  logic              CLK = 1'b0;
  logic              RSTN, CE, CLEAR;
  logic [DIV_W-1:0]  DIVIDER;
  logic [FRAC_W-1:0] FRAC;
  logic              BAUDTICK, BITTICK, SAMPLETICK, DIV_ZERO;
  logic [PH_W-1:0]   PHASE;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: CE cycles spent in the current period, total baud ticks
  // since restart, running sum of FRAC over all periods.
  int     m_elapsed, m_ntick, m_stretch;
  longint m_fsum;
  logic   e_baud, e_bit, e_samp, e_dz;

  always #5 CLK = ~CLK;

  uart_baudgen_frac dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .CE         (CE),
    .CLEAR      (CLEAR),
    .DIVIDER    (DIVIDER),
    .FRAC       (FRAC),
    .BAUDTICK   (BAUDTICK),
    .BITTICK    (BITTICK),
    .SAMPLETICK (SAMPLETICK),
    .PHASE      (PHASE),
    .DIV_ZERO   (DIV_ZERO)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0; m_ntick = 0; m_stretch = 0; m_fsum = 0;
    e_baud = 0; e_bit = 0; e_samp = 0; e_dz = 0;
  endtask

  task automatic model_clk();
    longint old;
    e_baud = 0; e_bit = 0; e_samp = 0;
    e_dz = (DIVIDER == 0);
    if (CLEAR) begin
      m_elapsed = 0; m_ntick = 0; m_stretch = 0; m_fsum = 0;
    end else if (CE && DIVIDER != 0) begin
      if (m_elapsed >= int'(DIVIDER) + m_stretch) begin
        m_elapsed = 0;
        m_ntick++;
        e_baud = 1;
        e_bit  = (m_ntick % OSR == 0);
        e_samp = (m_ntick % OSR == OSR / 2 - 1);
        old    = m_fsum;
`ifdef UART_BAUDGEN_FRAC_EN
        m_fsum    = m_fsum + FRAC;
        m_stretch = ((m_fsum >> FRAC_W) != (old >> FRAC_W)) ? 1 : 0;
`else
        m_fsum    = old;
        m_stretch = 0;
`endif
      end else begin
        m_elapsed++;
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_clk();
    @(negedge CLK);
    check_val("baudtick", BAUDTICK, e_baud);
    check_val("bittick", BITTICK, e_bit);
    check_val("sampletick", SAMPLETICK, e_samp);
    check_val("phase", PHASE, m_ntick % OSR);
    check_val("div_zero", DIV_ZERO, e_dz);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_baud"}, BAUDTICK, 0);
    check_val({tag, "_bit"}, BITTICK, 0);
    check_val({tag, "_samp"}, SAMPLETICK, 0);
    check_val({tag, "_phase"}, PHASE, 0);
    check_val({tag, "_dz"}, DIV_ZERO, 0);
  endtask

  task automatic do_clear();
    CLEAR = 1; step(); CLEAR = 0;
  endtask

  initial begin
    int first, cnt;
    RSTN = 0; CE = 0; CLEAR = 0; DIVIDER = 16'd3; FRAC = '0;
    model_reset();
    #12;
    check_all_zero("reset");

    // First tick on edge DIVIDER+1 after release.
    @(negedge CLK);
    RSTN = 1; CE = 1;
    first = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (BAUDTICK && first == 0) first = i;
    end
    check_val("first_tick_edge", first, 4);

    // CE at 1-in-2 duty, DIVIDER=2: period of 6 clocks.
    DIVIDER = 16'd2; do_clear();
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      CE = (i % 2 == 0);
      step();
      if (BAUDTICK) cnt++;
    end
    check_val("ce_half_ticks", cnt, 10);
    CE = 1;

    // Fractional divisor: 4 + 8/16.
    DIVIDER = 16'd4; FRAC = 4'd8; do_clear();
    cnt = 0;
    for (int i = 0; i < 88; i++) begin
      step();
      if (BAUDTICK) cnt++;
    end
`ifdef UART_BAUDGEN_FRAC_EN
    check_val("frac_ticks_88", cnt, 16);
`else
    check_val("frac_ticks_88", cnt, 17);
`endif
    FRAC = '0;

    // DIVIDER lowered below the running count ends the period next CE cycle.
    DIVIDER = 16'd20; do_clear();
    for (int i = 0; i < 10; i++) step();
    DIVIDER = 16'd5; step();
    check_val("div_lowered_tick", BAUDTICK, 1);
    for (int i = 0; i < 12; i++) step();

    // CLEAR coinciding with terminal count wins.
    DIVIDER = 16'd3; do_clear();
    for (int i = 0; i < 3; i++) step();
    do_clear();
    check_val("clr_tc_baud", BAUDTICK, 0);
    check_val("clr_tc_phase", PHASE, 0);

    // DIVIDER=0 stalls the generator.
    DIVIDER = 16'd0;
    for (int i = 0; i < 8; i++) step();
    check_val("div_zero_flag", DIV_ZERO, 1);
    DIVIDER = 16'd1;
    for (int i = 0; i < 40; i++) step();

    // Asynchronous reset mid-period.
    #2 RSTN = 0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge CLK);
    check_all_zero("rst_hold");
    RSTN = 1; DIVIDER = 16'd3;
    for (int i = 0; i < 20; i++) step();

    // Randomised segments.
    for (int seg = 0; seg < 80; seg++) begin
      int mode;
      DIVIDER = 16'($urandom_range(0, 9));
      FRAC    = 4'($urandom);
      mode    = $urandom_range(0, 2);
      for (int i = 0; i < 50; i++) begin
        CE    = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
        CLEAR = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 31) == 0) DIVIDER = 16'($urandom_range(0, 9));
        step();
      end
      CLEAR = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
